// File: rtl/hilo_pkg.sv
// Shared types for the HI/LO unit: commit-mode encodings and FSM state.
package hilo_pkg;

   typedef enum logic [1:0] {
      ACC_WR  = 2'b00,
      ACC_ADD = 2'b01,
      ACC_SUB = 2'b10
   } acc_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

endpackage

// File: rtl/hilo_acc.sv
// Combinational 2*DATA_W commit datapath: overwrite, add or subtract a result
// into the current {HI,LO}; carries and borrows cross from LO into HI.
module hilo_acc
   import hilo_pkg::*;
#(
   parameter int W = 64
) (
   input  logic [W-1:0] i_base,
   input  logic [W-1:0] i_opnd,
   input  logic [1:0]   i_mode,
   output logic [W-1:0] o_res
);

   always_comb begin
      case (i_mode)
         ACC_ADD: o_res = i_base + i_opnd;
         ACC_SUB: o_res = i_base - i_opnd;
         default: o_res = i_opnd;   // 00 and 11 both overwrite
      endcase
   end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register pair fed by multi-cycle units (MULT/DIV), with move-to
// writes, same-cycle forwarding of the committing result, and a timeout.
module hilo_unit
   import hilo_pkg::*;
#(
   parameter int  DATA_W  = 32,
   parameter int  NSRC    = 4,
   parameter int  TIMEOUT = 64,
   localparam int SRC_W   = (NSRC > 1) ? $clog2(NSRC) : 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   issue_valid,
   input  logic [SRC_W-1:0]       issue_src,
   input  logic [1:0]             issue_acc,
   input  logic [NSRC-1:0]        res_valid,
   input  logic [NSRC*DATA_W-1:0] res_hi,
   input  logic [NSRC*DATA_W-1:0] res_lo,
   input  logic                   mt_valid,
   input  logic                   mt_sel,
   input  logic [DATA_W-1:0]      mt_data,
   input  logic                   rd_req,
   output logic [DATA_W-1:0]      hi,
   output logic [DATA_W-1:0]      lo,
   output logic                   busy,
   output logic                   stall,
   output logic                   err
);

   localparam int W2    = 2 * DATA_W;
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   state_e             r_state, w_state_nxt;
   logic [SRC_W-1:0]   r_src;
   logic [1:0]         r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic               r_err;
   logic [DATA_W-1:0]  r_hi, r_lo;

   logic               w_in_wait, w_done, w_src_bad, w_load, w_err_set, w_mt_wr;
   logic [NSRC-1:0]    w_exp_mask;
   logic [W2-1:0]      w_res, w_commit;

   assign w_in_wait  = (r_state == ST_WAIT);
   assign w_done     = w_in_wait & res_valid[r_src];
   assign w_exp_mask = NSRC'(1) << r_src;
   assign w_res      = {res_hi[r_src*DATA_W +: DATA_W], res_lo[r_src*DATA_W +: DATA_W]};
   // Widen before comparing so a power-of-two NSRC does not yield a constant compare.
   assign w_src_bad  = (32'(issue_src) >= NSRC);

   hilo_acc #(.W(W2)) u_acc (
      .i_base ({r_hi, r_lo}),
      .i_opnd (w_res),
      .i_mode (r_acc),
      .o_res  (w_commit)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_err_set   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|res_valid) w_err_set = 1'b1;
            if (issue_valid) begin
               if (w_src_bad) begin
                  w_err_set = 1'b1;
               end else begin
                  w_load      = 1'b1;
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (|(res_valid & ~w_exp_mask)) w_err_set = 1'b1;
            if (w_done) begin
               w_state_nxt = ST_IDLE;
               if (issue_valid) begin
                  if (w_src_bad) begin
                     w_err_set = 1'b1;
                  end else begin
                     w_load      = 1'b1;
                     w_state_nxt = ST_WAIT;
                  end
               end
            end else begin
               if (issue_valid) w_err_set = 1'b1;
               if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  w_err_set   = 1'b1;
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign stall   = w_in_wait & ~w_done & (rd_req | mt_valid);
   assign w_mt_wr = mt_valid & ~stall;
   assign busy    = w_in_wait;
   assign err     = r_err;
   assign hi      = w_done ? w_commit[W2-1:DATA_W] : r_hi;
   assign lo      = w_done ? w_commit[DATA_W-1:0]  : r_lo;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_src   <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_load) begin
            r_src <= issue_src;
            r_acc <= issue_acc;
            r_cnt <= '0;
         end else if (w_in_wait) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_err_set) r_err <= 1'b1;
         // A move-to owns its half; the commit supplies whatever half remains.
         if (w_mt_wr && mt_sel)   r_hi <= mt_data;
         else if (w_done)         r_hi <= w_commit[W2-1:DATA_W];
         if (w_mt_wr && !mt_sel)  r_lo <= mt_data;
         else if (w_done)         r_lo <= w_commit[DATA_W-1:0];
      end
   end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the width of each of HI and LO.
REQ-002 SHALL have parameter NSRC, default 4, the number of multi-cycle result sources (DIVU, DIV, MULTU, MULT).
REQ-003 SHALL have parameter TIMEOUT, default 64, the maximum cycles spent waiting for a result.
REQ-004 SHALL have SRC_W = max(1, clog2(NSRC)) as a derived local constant.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 issue_valid  in  1  a multi-cycle operation is launched this cycle.
REQ-008 issue_src  in  SRC_W  index of the source that will return the result.
REQ-009 issue_acc  in  2  commit mode: 00 overwrite, 01 add, 10 subtract, 11 overwrite.
REQ-010 res_valid  in  NSRC  per-source result strobe.
REQ-011 res_hi, res_lo  in  NSRC*DATA_W each  per-source result halves; source i occupies slice i.
REQ-012 mt_valid  in  1  move-to request (MTHI/MTLO).
REQ-013 mt_sel  in  1  0 selects LO, 1 selects HI.
REQ-014 mt_data  in  DATA_W  move-to data.
REQ-015 rd_req  in  1  the pipeline reads HI/LO this cycle (MFHI/MFLO).
REQ-016 hi, lo  out  DATA_W each  architectural HI/LO, including same-cycle forwarding.
REQ-017 busy  out  1  an operation is outstanding.
REQ-018 stall  out  1  the pipeline must hold its request.
REQ-019 err  out  1  sticky protocol error flag.

Function
REQ-020 SHALL implement two states: IDLE and WAIT; busy SHALL be 1 exactly in WAIT.
REQ-021 In IDLE, issue_valid SHALL latch issue_src and issue_acc, clear the wait counter, and enter WAIT.
REQ-022 In WAIT, "done" SHALL be res_valid[latched src]; on done the commit SHALL occur at this edge and the state SHALL go to IDLE, unless issue_valid is also high, in which case the new op is latched and the state stays in WAIT.
REQ-023 Commit SHALL be {HI,LO} <= R for overwrite, {HI,LO} + R for add, and {HI,LO} - R for subtract, where R = {res_hi[src],res_lo[src]}; arithmetic is 2*DATA_W bits, modulo 2^(2*DATA_W), with carry/borrow crossing from LO to HI.
REQ-024 Combinationally, stall SHALL = WAIT & ~done & (rd_req | mt_valid).
REQ-025 When done, the hi/lo outputs SHALL show the commit value in the same cycle (bypass); otherwise they SHALL show the registered values.
REQ-026 An mt_valid with stall=0 SHALL write mt_data into the selected half at the edge.
REQ-027 If mt_valid coincides with a commit, mt SHALL win its half and the commit SHALL supply the other half.
REQ-028 If mt_valid and issue_valid occur together in IDLE, the mt write SHALL occur, and a later accumulating commit SHALL use the post-mt value.
REQ-029 err SHALL be set, with no effect on state, for:
  - a res_valid bit outside the expected source;
  - res_valid while IDLE;
  - issue_valid in WAIT without done;
  - issue_src >= NSRC.
REQ-030 The wait counter SHALL increment each WAIT cycle; on reaching TIMEOUT-1 without done, the block SHALL set err, return to IDLE, and leave HI/LO unchanged.

Reset
REQ-031 rst_n low SHALL immediately force HI=0, LO=0, state IDLE, latched src/acc=0, counter=0, err=0, giving busy=0 and stall=0.
REQ-032 Reset asserted mid-WAIT SHALL abandon the operation; a res_valid arriving after release SHALL set err.

Structure
REQ-033 Package hilo_pkg SHALL hold the commit-mode encodings (ACC_WR, ACC_ADD, ACC_SUB) and the state type.
REQ-034 The 2*DATA_W add/subtract SHALL be a combinational sub-module, hilo_acc.

Verification
REQ-035 Reset, then issue src=1 overwrite, then res_valid[1] 3 cycles later with hi=0x1, lo=0x2 -> busy high for 3 cycles, then HI=0x1, LO=0x2, visible in the done cycle.
REQ-036 HI=0, LO=0xFFFFFFFF, then add with R={0,1} -> HI=0x1, LO=0x0; subtract with R={0,1} from 0/0 -> HI=LO=0xFFFFFFFF.
REQ-037 rd_req in WAIT for 2 cycles before done -> stall=1 for those cycles, stall=0 in the done cycle, forwarded value correct.
REQ-038 mt_sel=1, mt_data=0xAA together with a commit of {0x5,0x6} -> HI=0xAA, LO=0x6.
REQ-039 res_valid[2] while waiting on src 0 -> err=1 and busy still 1; with TIMEOUT=8 and no result -> IDLE after 8 cycles, err=1, HI/LO unchanged.
REQ-040 rst_n pulsed mid-WAIT -> busy=0, HI=LO=0 immediately; a subsequent res_valid sets err.
